// File: rtl/flt_pds2_result_checker.sv
// rtl/flt_pds2_result_checker.sv - receive-side result checker for the flt_pds2 converter
//
// Accepts result beats from the converter (no back-pressure), compares each one
// against a registered-read expected-value ROM, counts passes and fails, latches
// the first mismatch and reports done / pass / timeout status.
//
// Optional feature macro: FLT_PDS2_CHK_TIMEOUT_EN
//   defined     - an idle-cycle watchdog ends a starved run in DONE with o_timeout=1
//   not defined - no watchdog is built, o_timeout is tied low
//
// Ports:
//   i_aclk, i_areset          clock, synchronous active-high reset
//   i_start                   one-cycle pulse: clear all run state and enter RUN
//   i_axi4s_result_tdata/
//   i_axi4s_result_tvalid     converter result stream, always accepted
//   o_exp_addr                expected-ROM address (current index)
//   i_exp_tdata               expected-ROM data, one cycle after o_exp_addr
//   o_pass_cnt, o_fail_cnt    saturating match / mismatch counters
//   o_first_fail_idx/_data    index and received word of the first mismatch
//   o_busy, o_done, o_pass,
//   o_timeout                 run status

module flt_pds2_result_checker #(
    parameter int                   TDATA_WIDTH    = 32,
    parameter int                   ADDR_WIDTH     = 4,
    parameter int                   NUM_VECTORS    = 16,
    parameter int                   TOTAL_BEATS    = 16,
    parameter int                   CNT_WIDTH      = 16,
    parameter logic [TDATA_WIDTH-1:0] CMP_MASK     = {TDATA_WIDTH{1'b1}},
    parameter int                   TIMEOUT_CYCLES = 1024
) (
    input  logic                   i_aclk,
    input  logic                   i_areset,
    input  logic                   i_start,
    input  logic [TDATA_WIDTH-1:0] i_axi4s_result_tdata,
    input  logic                   i_axi4s_result_tvalid,
    output logic [ADDR_WIDTH-1:0]  o_exp_addr,
    input  logic [TDATA_WIDTH-1:0] i_exp_tdata,
    output logic [CNT_WIDTH-1:0]   o_pass_cnt,
    output logic [CNT_WIDTH-1:0]   o_fail_cnt,
    output logic [ADDR_WIDTH-1:0]  o_first_fail_idx,
    output logic [TDATA_WIDTH-1:0] o_first_fail_data,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_pass,
    output logic                   o_timeout
);

    localparam int BEAT_W = (TOTAL_BEATS < 2) ? 1 : $clog2(TOTAL_BEATS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    accept;
    logic                    last_beat;
    logic                    timeout_hit;

    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [ADDR_WIDTH-1:0]   idx_inc;
    logic [BEAT_W-1:0]       beat_cnt_q;

    logic                    s1_valid_q;
    logic [TDATA_WIDTH-1:0]  s1_data_q;
    logic [ADDR_WIDTH-1:0]   s1_idx_q;
    logic                    match;

    logic [CNT_WIDTH-1:0]    pass_cnt_q;
    logic [CNT_WIDTH-1:0]    fail_cnt_q;
    logic [ADDR_WIDTH-1:0]   first_fail_idx_q;
    logic [TDATA_WIDTH-1:0]  first_fail_data_q;
    logic                    timeout_q;

    assign idx_inc   = (idx_q == ADDR_WIDTH'(NUM_VECTORS - 1)) ? '0 : idx_q + 1'b1;
    assign last_beat = (beat_cnt_q == BEAT_W'(TOTAL_BEATS - 1));
    assign match     = (((s1_data_q ^ i_exp_tdata) & CMP_MASK) == '0);

`ifdef FLT_PDS2_CHK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q;

    // Fires on the TIMEOUT_CYCLES-th consecutive idle RUN cycle, so DONE is
    // entered exactly TIMEOUT_CYCLES edges after the edge that took the last beat.
    assign timeout_hit = (state_q == ST_RUN) && !i_start && !i_axi4s_result_tvalid &&
                         (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            wd_q <= '0;
        end else if (i_start || accept) begin
            wd_q <= '0;
        end else if (state_q == ST_RUN) begin
            wd_q <= wd_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and beat acceptance; a start always wins over a beat.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (i_start) begin
                    state_d = ST_RUN;
                end else if (i_axi4s_result_tvalid) begin
                    accept = 1'b1;
                    if (last_beat) state_d = ST_DRAIN;
                end else if (timeout_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DRAIN: begin
                // The final compare happens in this cycle; DONE follows.
                state_d = i_start ? ST_RUN : ST_DONE;
            end
            ST_DONE: begin
                if (i_start) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset || i_start) begin
            idx_q             <= '0;
            beat_cnt_q        <= '0;
            s1_valid_q        <= 1'b0;
            s1_data_q         <= '0;
            s1_idx_q          <= '0;
            pass_cnt_q        <= '0;
            fail_cnt_q        <= '0;
            first_fail_idx_q  <= '0;
            first_fail_data_q <= '0;
            timeout_q         <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_data_q  <= i_axi4s_result_tdata;
                s1_idx_q   <= idx_q;
                idx_q      <= idx_inc;
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end

            // Compare stage is not gated by state so a beat still in s1 when
            // the run ends (drain or timeout) is always scored.
            if (s1_valid_q) begin
                if (match) begin
                    if (pass_cnt_q != '1) pass_cnt_q <= pass_cnt_q + 1'b1;
                end else begin
                    // fail_cnt saturates and never wraps, so zero means no
                    // failure has been seen yet in this run.
                    if (fail_cnt_q == '0) begin
                        first_fail_idx_q  <= s1_idx_q;
                        first_fail_data_q <= s1_data_q;
                    end
                    if (fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + 1'b1;
                end
            end

            if (timeout_hit) timeout_q <= 1'b1;
        end
    end

    assign o_exp_addr        = idx_q;
    assign o_pass_cnt        = pass_cnt_q;
    assign o_fail_cnt        = fail_cnt_q;
    assign o_first_fail_idx  = first_fail_idx_q;
    assign o_first_fail_data = first_fail_data_q;
    assign o_busy            = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign o_done            = (state_q == ST_DONE);
    assign o_timeout         = timeout_q;
    assign o_pass            = o_done && (fail_cnt_q == '0) && !timeout_q;

endmodule
